// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package inst_queue_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        ds;
      logic        pred_taken;
      logic [31:0] pred_target;
      logic [1:0]  exc;          // {tlb_ref, tlb_inv}
   } iq_entry_t;

   localparam logic [1:0] EXC_REF = 2'b10;
   localparam logic [1:0] EXC_INV = 2'b01;

endpackage

// File: rtl/iq_storage.sv
// Entry array: one synchronous write port, two asynchronous read ports.
module iq_storage
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  iq_entry_t     wdata,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output iq_entry_t     rdata1,
   output iq_entry_t     rdata2
);

   iq_entry_t [DEPTH-1:0] mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1 = mem[raddr1];
   assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and dual-issue decode: 1 write/cycle, 0-2 pops/cycle.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          w_ena,
   input  logic [31:0]   w_pc,
   input  logic [31:0]   w_inst,
   input  logic          w_fetch_ds,
   input  logic          w_pred_taken,
   input  logic [31:0]   w_pred_target,
   input  logic          w_tlb_ref,
   input  logic          w_tlb_inv,
   output logic          stall_req,
   input  logic [1:0]    r_pop,
   output logic          r_valid1,
   output logic          r_valid2,
   output logic [31:0]   r_pc1,
   output logic [31:0]   r_pc2,
   output logic [31:0]   r_inst1,
   output logic [31:0]   r_inst2,
   output logic          r_ds1,
   output logic          r_ds2,
   output logic          r_pred_taken1,
   output logic          r_pred_taken2,
   output logic [31:0]   r_pred_target1,
   output logic [31:0]   r_pred_target2,
   output logic [1:0]    r_exc1,
   output logic [1:0]    r_exc2,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL  = (AW+1)'(DEPTH-2);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          ovf;
   logic [1:0]    pop_clamp, pop_eff;
   logic [AW:0]   pop_ext;
   logic          room, wr_acc;
   iq_entry_t     wdata, e1, e2;

   assign pop_clamp = r_pop[1] ? 2'd2 : r_pop;

   // Popping past occupancy silently clamps to what is actually there.
   always_comb begin
      pop_eff = pop_clamp;
      if ({{(AW-1){1'b0}}, pop_clamp} > count) pop_eff = count[1:0];
   end

   assign pop_ext = {{(AW-1){1'b0}}, pop_eff};
   assign room    = (count - pop_ext) < FULL;
   assign wr_acc  = w_ena && !flush && room;

   assign wdata = '{pc: w_pc, inst: w_inst, ds: w_fetch_ds, pred_taken: w_pred_taken,
                    pred_target: w_pred_target, exc: {w_tlb_ref, w_tlb_inv}};

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_acc);
         rd_ptr <= rd_ptr + AW'(pop_eff);
         count  <= count + (AW+1)'(wr_acc) - pop_ext;
         if (w_ena && !room) ovf <= 1'b1;
      end
   end

   iq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
      .clk    (clk),
      .rst    (rst),
      .we     (wr_acc),
      .waddr  (wr_ptr),
      .wdata  (wdata),
      .raddr1 (rd_ptr),
      .raddr2 (rd_ptr + AW'(1)),
      .rdata1 (e1),
      .rdata2 (e2)
   );

   // Two-entry margin absorbs the PC stage's one-cycle stall reaction.
   assign stall_req = count >= AFULL;

   assign r_valid1       = count != '0;
   assign r_valid2       = count > (AW+1)'(1);
   assign r_pc1          = e1.pc;
   assign r_pc2          = e2.pc;
   assign r_inst1        = e1.inst;
   assign r_inst2        = e2.inst;
   assign r_ds1          = e1.ds;
   assign r_ds2          = e2.ds;
   assign r_pred_taken1  = e1.pred_taken;
   assign r_pred_taken2  = e2.pred_taken;
   assign r_pred_target1 = e1.pred_target;
   assign r_pred_target2 = e2.pred_target;
   assign r_exc1         = e1.exc;
   assign r_exc2         = e2.exc;

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the dual-issue decode stage. Accepts at most one fetched instruction per cycle from the fetch side, together with its PC, delay-slot flag, branch prediction and TLB-refill/invalid fetch exception flags. Presents the two oldest entries to decode each cycle and retires 0, 1 or 2 of them per decode's pop count. Generates the stall request that freezes the PC stage, and is emptied by pipeline flush.

## Interface
- DEPTH, 16, number of entries; power of two, at least 4
- AW, $clog2(DEPTH), pointer width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries, including any write in the same cycle
- w_ena  in  1  fetch entry valid this cycle
- w_pc  in  32  instruction PC
- w_inst  in  32  instruction word
- w_fetch_ds  in  1  entry is a branch delay slot
- w_pred_taken  in  1  predictor said taken
- w_pred_target  in  32  predicted target
- w_tlb_ref  in  1  fetch TLB refill exception
- w_tlb_inv  in  1  fetch TLB invalid exception
- stall_req  out  1  almost-full; stalls the PC stage
- r_pop  in  2  entries decode consumes this cycle: 0, 1, 2; 3 is treated as 2
- r_valid1, r_valid2  out  1  head / head+1 entry present
- r_pc1, r_pc2  out  32  PC of the head / head+1 entry
- r_inst1, r_inst2  out  32  instruction word
- r_ds1, r_ds2  out  1  delay-slot flag
- r_pred_taken1, r_pred_taken2  out  1  prediction-taken flag
- r_pred_target1, r_pred_target2  out  32  predicted target
- r_exc1, r_exc2  out  2  {tlb_ref, tlb_inv}
- count  out  AW+1  current occupancy

## Operation
- Circular buffer with registers wr_ptr, rd_ptr (AW bits, wrap modulo DEPTH) and count (AW+1 bits).
- Effective pop: pop_eff = min(r_pop clamped to 2, count). Popping beyond occupancy is clamped and is not an error.
- Write accepted when w_ena and (count − pop_eff) < DEPTH. An entry written while the queue is full and no pop occurs is dropped. Each dropped write sets the sticky debug bit `ovf`, which is cleared by rst only.
- Accepted write: the entry is stored at wr_ptr, and wr_ptr advances by 1.
- rd_ptr advances by pop_eff. count_next = count + accepted − pop_eff.
- Read outputs are combinational from storage at rd_ptr and rd_ptr+1 (modulo DEPTH).
  - r_valid1 = count ≥ 1; r_valid2 = count ≥ 2.
  - Data on an invalid slot is the stale storage content.
- stall_req = count ≥ DEPTH−2. The margin of 2 covers the PC stage's one-cycle stall reaction plus its held w_ena.
- flush has priority over write and pop: rd_ptr, wr_ptr and count all go to 0.
- rst: pointers, count, ovf and all storage go to 0. As a result, every output is 0 after reset.

## Timing
- Write-to-visible latency is 1 cycle. There is no empty bypass: an entry written in cycle N is first valid in cycle N+1.
- A pop takes effect at the clock edge; the next entries are presented in the following cycle.
- stall_req is a registered-count function, so it changes the cycle after the count crosses the threshold.
- Simultaneous write and pop at full with pop ≥ 1: the write is accepted and count stays at DEPTH.
- Simultaneous flush and w_ena: the write is dropped and count is 0 the next cycle.
- rst asserted mid-operation behaves as flush and additionally clears ovf and storage.
- Wrap-around: both pointers wrap silently. The head+1 read index wraps independently, so at rd_ptr=DEPTH−1 slot 2 reads entry 0.

## Structure
- Package inst_queue_pkg holds:
  - typedef iq_entry_t {pc, inst, ds, pred_taken, pred_target, exc[1:0]}, 100 bits
  - constants EXC_REF=2'b10 and EXC_INV=2'b01
- Sub-module iq_storage holds the entry array: 1 write port, 2 asynchronous read ports, DEPTH x 100 bits, synchronous reset of contents.
- Pointer, count and stall logic live in inst_queue.

## Test plan
- Reset, then write PCs 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles with r_pop=0 → count=3, r_pc1=0xbfc00000, r_pc2=0xbfc00004, r_valid1=r_valid2=1.
- With count=1, set r_pop=2 → count=0 next cycle, r_valid1=0, no underflow, rd_ptr advanced by 1.
- DEPTH=16: fill to 14 → stall_req=1. Continue writing to 16, then one more write with r_pop=0 → write dropped, count=16, ovf=1. Next cycle write with r_pop=1 → count stays 16.
- Fill 8 entries, assert flush together with w_ena → count=0, r_valid1=0 next cycle. A write 2 cycles later appears as head with r_pc1 = the written PC.
- Cycle 40 writes with r_pop=1 every cycle from cycle 2 → pointers wrap past 15. r_pc1 sequence matches write order with no gaps, and r_pc2 at rd_ptr=15 shows entry 0.
- Write an entry with w_tlb_ref=1, w_fetch_ds=1, w_pred_taken=1, w_pred_target=0x80001000 → r_exc1=2'b10, r_ds1=1, r_pred_taken1=1, r_pred_target1=0x80001000.
